// File: rtl/drbg_request_scheduler.sv
// drbg_request_scheduler
// Shares one hash DRBG between synchroniser seed advances, periodic
// (field-counted) reseeds and scrambler bits requests, keeping exactly one
// command in flight. Optional watchdog: define DRBG_SCHED_WATCHDOG_EN.
module drbg_request_scheduler #(
    parameter int unsigned RESEED_FIELDS  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_done,
    input  logic       drbg_ready,
    input  logic       block_drbg_reseed,
    input  logic       sync_seed_req,
    input  logic       bits_req,
    input  logic       vsync,
    output logic       drbg_next_seed,
    output logic       drbg_next_bits,
    output logic       sync_seed_ack,
    output logic       bits_ack,
    output logic       reseed_pending,
    output logic [7:0] sync_pending_cnt,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE, ST_ACK} state_t;
    typedef enum logic [1:0] {GR_SYNC, GR_PERIODIC, GR_BITS} grant_t;

    localparam logic [7:0] LP_LAST_FIELD = 8'(RESEED_FIELDS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    grant_t     r_grant;
    logic       r_busy;
    logic       r_last_bits;
    logic       r_bits_pend;
    logic       r_reseed_pend;
    logic       r_vsync_d;
    logic [7:0] r_sync_cnt;
    logic [7:0] r_field_cnt;
    logic       w_seed_elig;
    logic       w_bits_elig;
    logic       w_pick_seed;
    logic       w_grant;
    logic       w_vsync_rise;
    logic       w_periodic_done;
    logic       w_wd_expire;

    assign w_seed_elig     = !block_drbg_reseed && ((r_sync_cnt != '0) || r_reseed_pend);
    assign w_bits_elig     = r_bits_pend;
    // Alternate between classes when both want the DRBG.
    assign w_pick_seed     = w_seed_elig && (!w_bits_elig || r_last_bits);
    assign w_grant         = (r_state == ST_IDLE) && init_done && drbg_ready &&
                             (w_seed_elig || w_bits_elig);
    assign w_vsync_rise    = vsync && !r_vsync_d;
    assign w_periodic_done = init_done && (r_state == ST_ACK) && (r_grant == GR_PERIODIC);

    assign reseed_pending   = r_reseed_pend;
    assign sync_pending_cnt = r_sync_cnt;
    assign busy             = r_busy;

    // State register; busy registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state logic; init_done low or watchdog expiry abandons the command
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_grant) w_state_nxt = ST_ISSUE;
            ST_ISSUE:     w_state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!drbg_ready) w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (drbg_ready) w_state_nxt = ST_ACK;
            ST_ACK:       w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
        if (w_wd_expire || !init_done) w_state_nxt = ST_IDLE;
    end

    // Strobes and acks decoded from state and the latched grant
    always_comb begin
        drbg_next_seed = 1'b0;
        drbg_next_bits = 1'b0;
        sync_seed_ack  = 1'b0;
        bits_ack       = 1'b0;
        if (init_done) begin
            if (r_state == ST_ISSUE) begin
                drbg_next_seed = (r_grant != GR_BITS);
                drbg_next_bits = (r_grant == GR_BITS);
            end
            if (r_state == ST_ACK) begin
                sync_seed_ack = (r_grant == GR_SYNC);
                bits_ack      = (r_grant == GR_BITS);
            end
        end
    end

    // Latch the granted command and remember the class for fairness
    always_ff @(posedge clk) begin
        if (reset || !init_done) begin
            r_grant     <= GR_SYNC;
            r_last_bits <= 1'b1;
        end else if (w_grant) begin
            r_last_bits <= !w_pick_seed;
            if (!w_pick_seed)
                r_grant <= GR_BITS;
            else if (r_sync_cnt != '0)
                r_grant <= GR_SYNC;
            else
                r_grant <= GR_PERIODIC;
        end
    end

    // Outstanding sync seed requests, saturating at 255
    always_ff @(posedge clk) begin
        if (reset || !init_done) begin
            r_sync_cnt <= '0;
        end else if (sync_seed_req && !sync_seed_ack) begin
            if (r_sync_cnt != 8'hFF) r_sync_cnt <= r_sync_cnt + 8'd1;
        end else if (!sync_seed_req && sync_seed_ack) begin
            r_sync_cnt <= r_sync_cnt - 8'd1;
        end
    end

    // Bits request flag; a request in the ack cycle keeps it set
    always_ff @(posedge clk) begin
        if (reset || !init_done) r_bits_pend <= 1'b0;
        else                     r_bits_pend <= (r_bits_pend && !bits_ack) || bits_req;
    end

    // vsync edge detector
    always_ff @(posedge clk) begin
        if (reset) r_vsync_d <= 1'b0;
        else       r_vsync_d <= vsync;
    end

    // Field counter and periodic reseed flag (a flag, so edges never stack)
    always_ff @(posedge clk) begin
        if (reset || !init_done) begin
            r_field_cnt   <= '0;
            r_reseed_pend <= 1'b0;
        end else begin
            if (w_vsync_rise) begin
                if (r_field_cnt == LP_LAST_FIELD) begin
                    r_field_cnt   <= '0;
                    r_reseed_pend <= 1'b1;
                end else begin
                    r_field_cnt <= r_field_cnt + 8'd1;
                end
            end
            if (w_periodic_done) r_reseed_pend <= 1'b0;
        end
    end

`ifdef DRBG_SCHED_WATCHDOG_EN
    localparam logic [15:0] LP_WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wd_cnt;
    logic        r_timeout_err;
    logic        w_wd_waiting;

    assign w_wd_waiting = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE);
    assign w_wd_expire  = w_wd_waiting && (r_wd_cnt == LP_WD_LAST);
    assign timeout_err  = r_timeout_err;

    // Watchdog over the DRBG wait states; the request stays pending for retry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_wd_waiting && !w_wd_expire) r_wd_cnt <= r_wd_cnt + 16'd1;
            else                              r_wd_cnt <= '0;
            if (w_wd_expire) r_timeout_err <= 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_wd_expire      = 1'b0;
    assign timeout_err      = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_drbg_request_scheduler.sv
// Testbench for drbg_request_scheduler: directed scenarios plus randomized
// traffic, checked every cycle against a transaction-level timeline model.
`timescale 1ns/1ps
module tb_drbg_request_scheduler;

    localparam int unsigned RF = 4;
    localparam int unsigned TO = 16;
    localparam logic [7:0] CH_S = 8'h53;
    localparam logic [7:0] CH_B = 8'h42;

    logic       clk = 1'b0;
    logic       reset, init_done, drbg_ready, block_drbg_reseed;
    logic       sync_seed_req, bits_req, vsync;
    logic       drbg_next_seed, drbg_next_bits, sync_seed_ack, bits_ack;
    logic       reseed_pending, busy, timeout_err;
    logic [7:0] sync_pending_cnt;

    drbg_request_scheduler #(.RESEED_FIELDS(RF), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .init_done(init_done), .drbg_ready(drbg_ready),
        .block_drbg_reseed(block_drbg_reseed), .sync_seed_req(sync_seed_req),
        .bits_req(bits_req), .vsync(vsync), .drbg_next_seed(drbg_next_seed),
        .drbg_next_bits(drbg_next_bits), .sync_seed_ack(sync_seed_ack),
        .bits_ack(bits_ack), .reseed_pending(reseed_pending),
        .sync_pending_cnt(sync_pending_cnt), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;

    // DRBG environment: busy for cur_lat cycles after each observed strobe
    int env_left = 0;
    int cur_lat = 2;
    int lat_fixed = 2;

    // Reference model: pending bookkeeping plus the timeline of one command
    bit m_on = 1'b1;
    int m_cnt, m_field, m_cls, m_ts, m_ta;
    bit m_bits, m_resd, m_last_bits, m_infl, m_prev_vs;

    // Observation statistics
    int n_ss, n_bs, n_sa, n_ba, max_cnt, first_ss, first_sa;
    logic [7:0] order_q[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_field = 0; m_bits = 0; m_resd = 0; m_last_bits = 1; m_infl = 0;
    endtask

    task automatic stats_clear();
        n_ss = 0; n_bs = 0; n_sa = 0; n_ba = 0; max_cnt = 0; first_ss = -1; first_sa = -1;
        order_q.delete();
    endtask

    task automatic do_reset();
        reset = 1; init_done = 0; drbg_ready = 1; block_drbg_reseed = 0;
        sync_seed_req = 0; bits_req = 0; vsync = 0;
        repeat (2) @(negedge clk);
        chk("rst_next_seed", drbg_next_seed, 0);
        chk("rst_next_bits", drbg_next_bits, 0);
        chk("rst_sync_ack", sync_seed_ack, 0);
        chk("rst_bits_ack", bits_ack, 0);
        chk("rst_reseed_pending", reseed_pending, 0);
        chk("rst_pending_cnt", sync_pending_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 0;
        model_clear();
        m_prev_vs = 0; env_left = 0; cyc = 0;
    endtask

    // One clock cycle: drive, compare against the model, advance the model
    task automatic step(input bit sreq, input bit breq, input bit vs, input bit blk, input bit ini);
        bit e_ss, e_bs, e_sa, e_ba, e_busy, vrise, seed_ok, g_any;
        int g_cls;
        sync_seed_req = sreq; bits_req = breq; vsync = vs;
        block_drbg_reseed = blk; init_done = ini;
        drbg_ready = (env_left == 0);
        if (env_left > 0) env_left--;
        #1;
        if (drbg_next_seed) begin
            n_ss++; order_q.push_back(CH_S);
            if (first_ss < 0) first_ss = cyc;
        end
        if (drbg_next_bits) begin n_bs++; order_q.push_back(CH_B); end
        if (sync_seed_ack) begin n_sa++; if (first_sa < 0) first_sa = cyc; end
        if (bits_ack) n_ba++;
        if (int'(sync_pending_cnt) > max_cnt) max_cnt = int'(sync_pending_cnt);
        chk("one_strobe", {7'd0, drbg_next_seed & drbg_next_bits}, 8'd0);

        e_ss   = m_infl && cyc == m_ts && m_cls != 3 && ini;
        e_bs   = m_infl && cyc == m_ts && m_cls == 3 && ini;
        e_sa   = m_infl && cyc == m_ta && m_cls == 1 && ini;
        e_ba   = m_infl && cyc == m_ta && m_cls == 3 && ini;
        e_busy = m_infl && cyc >= m_ts;
        if (m_on) begin
            chk("next_seed", drbg_next_seed, e_ss);
            chk("next_bits", drbg_next_bits, e_bs);
            chk("sync_ack", sync_seed_ack, e_sa);
            chk("bits_ack", bits_ack, e_ba);
            chk("busy", busy, e_busy);
            chk("pending_cnt", sync_pending_cnt, 8'(m_cnt));
            chk("reseed_pending", reseed_pending, m_resd);
            chk("timeout_err", timeout_err, 0);
        end
        if (drbg_next_seed || drbg_next_bits) env_left = cur_lat;

        vrise = vs && !m_prev_vs;
        m_prev_vs = vs;
        if (!ini) begin
            model_clear();
        end else begin
            seed_ok = !blk && (m_cnt > 0 || m_resd);
            g_any   = !m_infl && drbg_ready && (seed_ok || m_bits);
            if (seed_ok && (!m_bits || m_last_bits)) g_cls = (m_cnt > 0) ? 1 : 2;
            else                                      g_cls = 3;
            if (sreq && !e_sa) begin
                if (m_cnt < 255) m_cnt++;
            end else if (!sreq && e_sa) begin
                m_cnt--;
            end
            m_bits = (m_bits && !e_ba) || breq;
            if (vrise) begin
                if (m_field == int'(RF) - 1) begin m_field = 0; m_resd = 1; end
                else m_field++;
            end
            if (m_infl && cyc == m_ta && m_cls == 2) m_resd = 0;
            if (m_infl && cyc == m_ta) begin
                m_infl = 0;
            end else if (g_any) begin
                m_infl = 1; m_cls = g_cls; m_last_bits = (g_cls == 3);
                cur_lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(5, 1));
                m_ts = cyc + 1;
                m_ta = cyc + 3 + cur_lat;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit blk, vs;
        logic [7:0] exp_ord [4];
        exp_ord[0] = CH_S; exp_ord[1] = CH_B; exp_ord[2] = CH_S; exp_ord[3] = CH_S;
        @(negedge clk);

        // Single seed: strobe two cycles after the request, ack lat+2 later
        do_reset();
        lat_fixed = 2;
        idle(2);
        stats_clear();
        begin
            int t0;
            t0 = cyc;
            step(1, 0, 0, 0, 1);
            idle(10);
            chk("single_strobe_delay", 8'(first_ss - t0), 8'd2);
            chk("single_ack_delay", 8'(first_sa - first_ss), 8'd4);
            chk("single_strobes", 8'(n_ss), 8'd1);
            chk("single_acks", 8'(n_sa), 8'd1);
            chk("single_cnt_final", sync_pending_cnt, 8'd0);
        end

        // Burst of five with a 3-cycle DRBG
        lat_fixed = 3;
        stats_clear();
        repeat (5) step(1, 0, 0, 0, 1);
        idle(40);
        chk("burst_peak", 8'(max_cnt), 8'd5);
        chk("burst_strobes", 8'(n_ss), 8'd5);
        chk("burst_acks", 8'(n_sa), 8'd5);

        // Fairness: seed, bits, seed, seed
        do_reset();
        lat_fixed = 2;
        stats_clear();
        step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        idle(40);
        chk("fair_len", 8'(order_q.size()), 8'd4);
        for (int i = 0; i < 4 && i < order_q.size(); i++) chk("fair_order", order_q[i], exp_ord[i]);

        // Periodic: eight vsync edges give two reseeds and no acks
        do_reset();
        stats_clear();
        for (int e = 0; e < 8; e++) begin
            repeat (3) step(0, 0, 1, 0, 1);
            repeat (3) step(0, 0, 0, 0, 1);
        end
        idle(20);
        chk("periodic_strobes", 8'(n_ss), 8'd2);
        chk("periodic_sync_acks", 8'(n_sa), 8'd0);
        chk("periodic_bits_acks", 8'(n_ba), 8'd0);

        // Block: only bits proceeds until the block lifts
        stats_clear();
        step(1, 1, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        repeat (20) step(0, 0, 0, 1, 1);
        chk("block_bits_strobes", 8'(n_bs), 8'd1);
        chk("block_seed_strobes", 8'(n_ss), 8'd0);
        stats_clear();
        idle(30);
        chk("unblock_seed_strobes", 8'(n_ss), 8'd2);
        chk("unblock_sync_acks", 8'(n_sa), 8'd2);

        // Saturation at 255, then init_done low clears it
        repeat (260) step(1, 0, 0, 1, 1);
        chk("sat_cnt", sync_pending_cnt, 8'hFF);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("init_clear_cnt", sync_pending_cnt, 8'd0);

        // Randomized traffic
        lat_fixed = 0;
        blk = 0; vs = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(19, 0) == 0) blk = !blk;
            if ($urandom_range(6, 0) == 0) vs = !vs;
            step($urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0, vs, blk,
                 $urandom_range(99, 0) != 0);
        end
        lat_fixed = 2;
        idle(20);

`ifdef DRBG_SCHED_WATCHDOG_EN
        // Watchdog: DRBG never finishes, then recovers and the request retries
        do_reset();
        m_on = 0;
        lat_fixed = 1000000;
        idle(2);
        stats_clear();
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 10 && first_ss < 0; i++) idle(1);
        chk("wd_strobe_seen", {7'd0, first_ss >= 0}, 8'd1);
        if (first_ss >= 0) begin
            while (cyc < first_ss + int'(TO)) idle(1);
            chk("wd_busy_before", busy, 1);
            chk("wd_err_before", timeout_err, 0);
            idle(1);
            chk("wd_busy_after", busy, 0);
            chk("wd_err_after", timeout_err, 1);
            chk("wd_cnt_kept", sync_pending_cnt, 8'd1);
        end
        env_left = 0; lat_fixed = 2; cur_lat = 2;
        stats_clear();
        idle(15);
        chk("wd_retry_strobes", 8'(n_ss), 8'd1);
        chk("wd_retry_acks", 8'(n_sa), 8'd1);
        chk("wd_retry_cnt", sync_pending_cnt, 8'd0);
        chk("wd_err_sticky", timeout_err, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
